serial_even_parity_check_ctrl: RTL and testbench

//  Sequencer for the even-parity checker datapath: takes a frame one bit per handshake
//  (DATA_BITS data bits, then 1 even-parity bit) and accumulates the XOR of every bit.
//  It presents the data word plus error flag C on a valid/ready output and keeps a

---
 rtl/serial_even_parity_check_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_even_parity_check_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_even_parity_check_ctrl.sv
// Even-parity frame receiver sequencer: shifts in DATA_BITS data bits plus one parity bit,
// presents WORD/C on a valid/ready output and keeps a saturating count of bad frames.
module serial_even_parity_check_ctrl #(
    parameter int DATA_BITS = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 BIT_IN,
    input  logic                 BIT_VALID,
    output logic                 BIT_READY,
    output logic [DATA_BITS-1:0] WORD,
    output logic                 C,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [CNT_W-1:0]     ERR_COUNT,
    output logic                 BUSY
);

    localparam int                BCNT_W   = $clog2(DATA_BITS + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [BCNT_W-1:0]      bit_cnt_r;
    logic                   acc_r;
    logic [DATA_BITS-1:0]   word_r;
    logic [DATA_BITS:0]     word_ext_s;
    logic [DATA_BITS-1:0]   word_shift_s;
    logic                   c_r;
    logic [CNT_W-1:0]       err_cnt_r;
    logic                   ready_r;
    logic                   valid_r;
    logic                   busy_r;
    logic                   accept_s;
    logic                   last_bit_s;
    logic                   transfer_s;
    logic                   frame_start_s;

    function automatic logic parity_fold(input logic acc, input logic bit_v);
        return acc ^ bit_v;
    endfunction

    // Handshake decode, word shift and next-state selection.
    always_comb begin
        accept_s      = (state_r == SHIFT) && BIT_VALID && !ABORT;
        last_bit_s    = (bit_cnt_r == LAST_BIT);
        transfer_s    = (state_r == HOLD) && OUT_READY;
        frame_start_s = ((state_r == IDLE) || transfer_s) && START;
        word_ext_s    = {word_r, BIT_IN};
        word_shift_s  = word_ext_s[DATA_BITS-1:0];
        state_nxt_s   = state_r;
        case (state_r)
            IDLE: begin
                if (START) state_nxt_s = SHIFT;
                else       state_nxt_s = IDLE;
            end
            SHIFT: begin
                if (ABORT)                       state_nxt_s = IDLE;
                else if (accept_s && last_bit_s) state_nxt_s = HOLD;
                else                             state_nxt_s = SHIFT;
            end
            HOLD: begin
                if (transfer_s) begin
                    if (START) state_nxt_s = SHIFT;
                    else       state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and the status outputs registered from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == SHIFT);
            valid_r <= (state_nxt_s == HOLD);
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Frame datapath: bit counter, parity accumulator, data word, error flag and counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt_r <= {BCNT_W{1'b0}};
            acc_r     <= 1'b0;
            word_r    <= {DATA_BITS{1'b0}};
            c_r       <= 1'b0;
            err_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (frame_start_s) begin
                bit_cnt_r <= {BCNT_W{1'b0}};
                acc_r     <= 1'b0;
                word_r    <= {DATA_BITS{1'b0}};
            end else if (accept_s) begin
                acc_r <= parity_fold(acc_r, BIT_IN);
                // The parity bit only closes the accumulation; it is never stored in WORD.
                if (last_bit_s) begin
                    c_r <= parity_fold(acc_r, BIT_IN);
                end else begin
                    word_r    <= word_shift_s;
                    bit_cnt_r <= bit_cnt_r + 1'b1;
                end
            end
            if (transfer_s && c_r && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + 1'b1;
            end
        end
    end

    assign BIT_READY = ready_r;
    assign OUT_VALID = valid_r;
    assign BUSY      = busy_r;
    assign WORD      = word_r;
    assign C         = c_r;
    assign ERR_COUNT = err_cnt_r;

endmodule

// File: tb/tb_serial_even_parity_check_ctrl.sv
// Bench for serial_even_parity_check_ctrl: random and directed frames checked against a
// frame-level model (WORD = first three bits, C = XOR of all four, error count = min(n, max)).
module tb_serial_even_parity_check_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, bit_in, bit_valid, out_ready;
    logic       bit_ready, c, out_valid, busy;
    logic [2:0] word;
    logic [7:0] err_count;
    logic       bit_ready2, c2, out_valid2, busy2;
    logic [2:0] word2;
    logic [1:0] err_count2;

    int checks   = 0;
    int failures = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    serial_even_parity_check_ctrl #(.DATA_BITS(3), .CNT_W(8)) dut (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .BIT_IN(bit_in),
        .BIT_VALID(bit_valid), .BIT_READY(bit_ready), .WORD(word), .C(c),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .ERR_COUNT(err_count), .BUSY(busy)
    );

    serial_even_parity_check_ctrl #(.DATA_BITS(3), .CNT_W(2)) dut_sat (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .BIT_IN(bit_in),
        .BIT_VALID(bit_valid), .BIT_READY(bit_ready2), .WORD(word2), .C(c2),
        .OUT_VALID(out_valid2), .OUT_READY(out_ready), .ERR_COUNT(err_count2), .BUSY(busy2)
    );

    function automatic int sat(input int n, input int max_v);
        return (n > max_v) ? max_v : n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_err = 0;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends the first nbits of frame f (MSB first), with 0..max_gap idle cycles before each bit.
    task automatic send_bits(input logic [3:0] f, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            int gap;
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g < gap; g++) tick();
            checks++;
            if (bit_ready !== 1'b1) begin
                failures++;
                $display("FAIL send_ready bit=%0d got=%b want=1", i, bit_ready);
            end
            bit_valid = 1'b1;
            bit_in    = f[3-i];
            tick();
            bit_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({out_valid, bit_ready, busy, c} !== 4'b0000 || word !== 3'b000 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b r=%b b=%b c=%b w=%b e=%0d want all zero",
                     out_valid, bit_ready, busy, c, word, err_count);
        end
    endtask

    task automatic test_single_frame();
        begin_frame();
        checks++;
        if (busy !== 1'b1 || bit_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_shift got busy=%b ready=%b want 1 1", busy, bit_ready);
        end
        out_ready = 1'b1;
        send_bits(4'b1010, 4, 0);
        checks++;
        if (out_valid !== 1'b1 || word !== 3'b101 || c !== 1'b0) begin
            failures++;
            $display("FAIL single_result got v=%b w=%b c=%b want 1 101 0", out_valid, word, c);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL single_after got v=%b busy=%b e=%0d want 0 0 0", out_valid, busy, err_count);
        end
    endtask

    task automatic test_back_to_back();
        begin_frame();
        for (int f = 0; f < 16; f++) begin
            logic [3:0] fr;
            fr = 4'(f);
            send_bits(fr, 4, 0);
            checks++;
            if (out_valid !== 1'b1 || word !== fr[3:1] || c !== (^fr)) begin
                failures++;
                $display("FAIL b2b_result frame=%0d got v=%b w=%b c=%b want 1 %b %b",
                         f, out_valid, word, c, fr[3:1], ^fr);
            end
            out_ready = 1'b1;
            start     = (f != 15);
            tick();
            out_ready = 1'b0;
            start     = 1'b0;
            if (^fr) n_err++;
            checks++;
            if (err_count !== 8'(sat(n_err, 255)) || err_count2 !== 2'(sat(n_err, 3))) begin
                failures++;
                $display("FAIL b2b_errcnt frame=%0d got %0d/%0d want %0d/%0d",
                         f, err_count, err_count2, sat(n_err, 255), sat(n_err, 3));
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== (f != 15)) begin
                failures++;
                $display("FAIL b2b_nogap frame=%0d got v=%b busy=%b want 0 %b", f, out_valid, busy, f != 15);
            end
        end
        checks++;
        if (err_count !== 8'd8) begin
            failures++;
            $display("FAIL b2b_total got %0d want 8", err_count);
        end
    endtask

    task automatic test_hold_stall();
        int base;
        base = n_err;
        begin_frame();
        send_bits(4'b1110, 4, 0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || word !== 3'b111 || c !== 1'b1 || bit_ready !== 1'b0 ||
                err_count !== 8'(base)) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got v=%b w=%b c=%b r=%b e=%0d want 1 111 1 0 %0d",
                         k, out_valid, word, c, bit_ready, err_count, base);
            end
            start = (k == 2);
            abort = (k == 3);
            tick();
            start = 1'b0;
            abort = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_err++;
        checks++;
        if (err_count !== 8'(n_err) || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_transfer got e=%0d v=%b busy=%b want %0d 0 0", err_count, out_valid, busy, n_err);
        end
    endtask

    task automatic test_gaps();
        for (int t = 0; t < 10; t++) begin
            logic [3:0] fr;
            fr = 4'($urandom_range(15, 0));
            begin_frame();
            send_bits(fr, 4, 3);
            checks++;
            if (out_valid !== 1'b1 || word !== fr[3:1] || c !== (^fr)) begin
                failures++;
                $display("FAIL gaps_result frame=%b got v=%b w=%b c=%b want 1 %b %b",
                         fr, out_valid, word, c, fr[3:1], ^fr);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (^fr) n_err++;
            checks++;
            if (err_count !== 8'(sat(n_err, 255))) begin
                failures++;
                $display("FAIL gaps_errcnt got %0d want %0d", err_count, sat(n_err, 255));
            end
        end
    endtask

    task automatic test_abort_reset();
        begin_frame();
        send_bits(4'b1100, 2, 1);
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        abort = 1'b0; bit_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bit_ready !== 1'b0 || err_count !== 8'(n_err)) begin
            failures++;
            $display("FAIL abort_idle got v=%b busy=%b r=%b e=%0d want 0 0 0 %0d",
                     out_valid, busy, bit_ready, err_count, n_err);
        end
        begin_frame();
        send_bits(4'b1011, 2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_err = 0;
        checks++;
        if ({out_valid, bit_ready, busy, c} !== 4'b0000 || word !== 3'b000 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL midframe_reset got v=%b r=%b b=%b c=%b w=%b e=%0d want all zero",
                     out_valid, bit_ready, busy, c, word, err_count);
        end
        begin_frame();
        send_bits(4'b0110, 4, 0);
        checks++;
        if (out_valid !== 1'b1 || word !== 3'b011 || c !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_frame got v=%b w=%b c=%b want 1 011 0", out_valid, word, c);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int t = 0; t < 5; t++) begin
            begin_frame();
            send_bits(4'b0001, 4, 0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_err++;
            checks++;
            if (err_count2 !== 2'(sat(n_err, 3)) || err_count !== 8'(n_err)) begin
                failures++;
                $display("FAIL saturate frame=%0d got %0d/%0d want %0d/%0d",
                         t, err_count2, err_count, sat(n_err, 3), n_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_hold_stall();
        test_gaps();
        test_abort_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
